// File: rtl/dataram_arbiter.sv
// -----------------------------------------------------------------------------
// dataram_arbiter
//
// Shares one asynchronous-read data RAM between the core's MEM-stage data port
// and a loader/debug port. The core has fixed priority because its read data is
// consumed in the same cycle. The loader uses a req/gnt handshake. A starvation
// counter bounds the loader's wait: after MAX_WAIT lost cycles the loader is
// forced through, and core_hold freezes the core pipeline for that one cycle.
//
// Optional feature macro: DATARAM_ARB_STATS_EN
//   When defined, adds saturating 16-bit counters stat_ld_grants and
//   stat_forced. Arbitration behaviour is identical either way.
//
// Ports:
//   CLOCK, RST_n        clock, asynchronous active-low reset
//   core_rd/core_wr     core read/write enables (ena_rd/ena_wr)
//   core_addr/wdata     core address (alu_out_ext) and write data
//   core_rdata          read data to the core (wired to ram_rdata)
//   core_hold           freeze core pipeline registers and PC this cycle
//   ld_req/ld_we        loader request, write(1)/read(0)
//   ld_addr/ld_wdata    loader address and write data
//   ld_gnt              loader transfer occurs this cycle (combinational)
//   ld_rvalid/ld_rdata  registered loader read data, one-cycle valid pulse
//   ram_rd/ram_wr       RAM read/write enables
//   ram_addr/ram_wdata  RAM address and write data
//   ram_rdata           RAM combinational read data
//   stat_ld_grants      (macro only) number of loader grants, saturating
//   stat_forced         (macro only) number of core_hold cycles, saturating
// -----------------------------------------------------------------------------
module dataram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic              CLOCK,
  input  logic              RST_n,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_hold,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef DATARAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_ld_grants,
  output logic [15:0]       stat_forced
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MaxWaitC = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             core_busy;
  logic             ld_rvalid_q, ld_rvalid_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  assign core_busy  = core_rd | core_wr;
  // Saturate so the counter can never wrap past the force threshold.
  assign cnt_inc    = (cnt_q >= MaxWaitC) ? cnt_q : cnt_q + OneC;
  assign core_rdata = ram_rdata;

  // ---------------------------------------------------------------------------
  // Arbitration FSM: next state, counter and grant/hold
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_gnt    = 1'b0;
    core_hold = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ld_req) begin
          if (!core_busy) begin
            ld_gnt = 1'b1;
          end else begin
            // First lost cycle; with MAX_WAIT = 1 it already triggers a force.
            cnt_d   = OneC;
            state_d = (MaxWaitC <= OneC) ? ST_FORCE : ST_PEND;
          end
        end
      end

      ST_PEND: begin
        if (!ld_req) begin
          // Loader abandoned its request: drop back without granting.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!core_busy) begin
          ld_gnt  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= MaxWaitC) begin
            state_d = ST_FORCE;
          end
        end
      end

      ST_FORCE: begin
        // The loader goes through regardless; the core is frozen only if it
        // actually wanted the RAM this cycle.
        ld_gnt    = ld_req;
        core_hold = ld_req & core_busy;
        state_d   = ST_IDLE;
        cnt_d     = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    if (ld_gnt) begin
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
      ram_wr    = ld_we;
      ram_rd    = !ld_we;
    end else begin
      ram_addr  = core_addr;
      ram_wdata = core_wdata;
      ram_wr    = core_wr;
      // A simultaneous core read and write is treated as a write.
      ram_rd    = core_rd & !core_wr;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader read-data capture
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_rvalid_d = ld_gnt & !ld_we;
    ld_rdata_d  = ld_rvalid_d ? ram_rdata : ld_rdata_q;
  end

  assign ld_rvalid = ld_rvalid_q;
  assign ld_rdata  = ld_rdata_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_rvalid_q <= ld_rvalid_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

`ifdef DATARAM_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Optional statistics counters, saturating at 0xFFFF
  // ---------------------------------------------------------------------------
  logic [15:0] stat_grants_q, stat_grants_d;
  logic [15:0] stat_forced_q, stat_forced_d;

  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_forced_d = stat_forced_q;
    if (ld_gnt && (stat_grants_q != 16'hFFFF)) begin
      stat_grants_d = stat_grants_q + 16'd1;
    end
    if (core_hold && (stat_forced_q != 16'hFFFF)) begin
      stat_forced_d = stat_forced_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      stat_grants_q <= '0;
      stat_forced_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_forced_q <= stat_forced_d;
    end
  end

  assign stat_ld_grants = stat_grants_q;
  assign stat_forced    = stat_forced_q;
`endif

endmodule
